div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  32  dividend (two's complement), taken from register A.
REQ-006 b  input  32  divisor (two's complement), taken from register B.
REQ-007 hi  output  32  remainder of the last completed division; feeds the HI register mux.
REQ-008 lo  output  32  quotient of the last completed division; feeds the LO register mux.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse when hi/lo have been updated or a divide-by-zero is reported.
REQ-011 div_zero  output  1  one-cycle pulse, coincident with done, when the divisor was zero; goes to the control unit exception logic.

Function
REQ-012 Semantics SHALL match MIPS div: quotient truncated toward zero, remainder has the sign of the dividend, a = lo*b + hi.
REQ-013 The datapath SHALL be restoring division on operand magnitudes, one quotient bit per cycle, with sign correction applied at completion.
REQ-014 FSM states SHALL be IDLE and CALC only.
REQ-015 IDLE: start=1 at edge E0 with b!=0 -> latch |a|, |b| and both sign bits, clear partial remainder, iteration counter = 0, go to CALC, busy=1.
REQ-016 IDLE: start=1 at E0 with b==0 -> stay in IDLE; at E0 set done=1 and div_zero=1 for exactly one cycle; hi, lo unchanged; busy stays 0.
REQ-017 CALC SHALL perform one shift-subtract step per edge for 32 edges (E1..E32); the counter is 6 bits and SHALL NOT wrap during a division.
REQ-018 At E33 the block SHALL write the sign-corrected quotient to lo and remainder to hi, pulse done for one cycle, clear busy and return to IDLE.
REQ-019 Total latency SHALL be 33 clock edges from the start sample to hi/lo/done valid.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the operation in progress; a and b are not re-sampled during CALC.
REQ-021 start asserted in the cycle done=1 (state IDLE) SHALL be accepted as a new division.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0x00000000, with no error flag.
REQ-023 hi and lo SHALL hold their values between divisions; done and div_zero are 0 in all cycles not named above.

Reset
REQ-024 reset=0 SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and clear the counter and internal registers, independent of clk.
REQ-025 Reset asserted mid-CALC SHALL abandon the division; after release no done pulse is produced until a new start.

Verification
REQ-026 a=7, b=2, start one cycle -> busy high for 33 cycles; at E33 lo=0x00000003, hi=0x00000001, done pulses once.
REQ-027 a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-028 First divide 7/2, then a=5, b=0 -> at E0 done=1 and div_zero=1 for one cycle; busy stays 0; hi=1 and lo=3 are retained.
REQ-029 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-030 Start 100/7, pulse start again with different operands at cycle 5, assert reset low at cycle 10 -> the second start has no effect; at reset all outputs are 0 immediately; no done follows; a fresh 100/7 then yields lo=14, hi=2.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and result bus between the register file / control unit and the
// signed 32-bit divider.
interface div_unit_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   modport master (
      output start, a, b,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  start, a, b,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// Signed 32-bit divider with MIPS div semantics.
// The datapath runs restoring division on operand magnitudes. It produces one
// quotient bit per clock. The signs are applied when the result is written to
// hi (remainder) and lo (quotient). A zero divisor is reported in the same
// cycle and starts no iteration.

// Invariant checker for the divider's registered outputs.
module div_unit_chk (
   input logic       clk,
   input logic       reset,
   input logic       busy,
   input logic       done,
   input logic       divZero,
   input logic [5:0] cnt
);
   // A divide-by-zero report is always part of a done pulse.
   zeroImpliesDone : assert property (@(posedge clk) disable iff (!reset) divZero |-> done);
   // done is raised only in IDLE, so busy is already low.
   doneNotBusy     : assert property (@(posedge clk) disable iff (!reset) done |-> !busy);
   // The iteration counter never goes beyond the final step count.
   cntBounded      : assert property (@(posedge clk) disable iff (!reset) cnt <= 6'd32);
endmodule

module div_unit (
   input logic        clk,
   input logic        reset,
   div_unit_if.slave  divIf
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } stateT;

   stateT       stateR;
   logic [5:0]  cntR;
   logic [31:0] divisorR;     // |b|
   logic [31:0] quotR;        // |a| shifted out MSB-first, quotient bits shifted in
   logic [31:0] remR;         // partial remainder, always < divisorR
   logic        signAR;
   logic        signBR;
   logic [31:0] hiR;
   logic [31:0] loR;
   logic        busyR;
   logic        doneR;
   logic        divZeroR;

   logic [32:0] remShiftS;
   logic [31:0] subS;
   logic        geS;
   logic [31:0] remNextS;
   logic [31:0] quotNextS;
   logic [31:0] loFinalS;
   logic [31:0] hiFinalS;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
   // its correct unsigned magnitude.
   function automatic logic [31:0] absVal(input logic [31:0] v);
      logic [31:0] r;
      if (v[31]) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Conditional two's-complement negation used for the final sign correction.
   function automatic logic [31:0] negIf(input logic [31:0] v, input logic neg);
      logic [31:0] r;
      if (neg) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits.
   always_comb begin
      remShiftS = {remR, quotR[31]};
      geS       = (remShiftS >= {1'b0, divisorR});
      // When the divisor fits, the true difference is below 2^31, so a 32-bit
      // subtraction gives the exact result.
      subS      = remShiftS[31:0] - divisorR;
      if (geS) begin
         remNextS  = subS;
         quotNextS = {quotR[30:0], 1'b1};
      end else begin
         remNextS  = remShiftS[31:0];
         quotNextS = {quotR[30:0], 1'b0};
      end
   end

   // Sign correction: quotient is negative iff the operand signs differ; the
   // remainder takes the sign of the dividend.
   always_comb begin
      loFinalS = negIf(quotR, signAR ^ signBR);
      hiFinalS = negIf(remR, signAR);
   end

   // Control FSM and datapath registers. done and div_zero default low so that
   // they pulse for exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateR   <= IDLE;
         cntR     <= 6'd0;
         divisorR <= 32'd0;
         quotR    <= 32'd0;
         remR     <= 32'd0;
         signAR   <= 1'b0;
         signBR   <= 1'b0;
         hiR      <= 32'd0;
         loR      <= 32'd0;
         busyR    <= 1'b0;
         doneR    <= 1'b0;
         divZeroR <= 1'b0;
      end else begin
         doneR    <= 1'b0;
         divZeroR <= 1'b0;
         case (stateR)
            IDLE: begin
               if (divIf.start) begin
                  if (divIf.b == 32'd0) begin
                     // Report the exception at once and leave hi/lo untouched.
                     doneR    <= 1'b1;
                     divZeroR <= 1'b1;
                  end else begin
                     divisorR <= absVal(divIf.b);
                     quotR    <= absVal(divIf.a);
                     remR     <= 32'd0;
                     signAR   <= divIf.a[31];
                     signBR   <= divIf.b[31];
                     cntR     <= 6'd0;
                     busyR    <= 1'b1;
                     stateR   <= CALC;
                  end
               end else begin
                  stateR <= IDLE;
               end
            end
            CALC: begin
               if (cntR == 6'd32) begin
                  // All 32 quotient bits are in; publish the signed result.
                  loR    <= loFinalS;
                  hiR    <= hiFinalS;
                  doneR  <= 1'b1;
                  busyR  <= 1'b0;
                  stateR <= IDLE;
               end else begin
                  remR  <= remNextS;
                  quotR <= quotNextS;
                  cntR  <= cntR + 6'd1;
               end
            end
            default: begin
               stateR <= IDLE;
               busyR  <= 1'b0;
            end
         endcase
      end
   end

   assign divIf.hi       = hiR;
   assign divIf.lo       = loR;
   assign divIf.busy     = busyR;
   assign divIf.done     = doneR;
   assign divIf.div_zero = divZeroR;

   div_unit_chk uChk (
      .clk     (clk),
      .reset   (reset),
      .busy    (busyR),
      .done    (doneR),
      .divZero (divZeroR),
      .cnt     (cntR)
   );

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. Directed corner cases and random operands
// are compared against a signed 64-bit arithmetic reference.
module tb_div_unit;

   logic clk = 1'b0;
   logic reset;

   div_unit_if divIf ();

   div_unit dut (
      .clk   (clk),
      .reset (reset),
      .divIf (divIf)
   );

   always #5 clk = ~clk;

   int          assertCnt = 0;
   int          failCnt   = 0;
   logic [31:0] lastHi;
   logic [31:0] lastLo;

   // Compare one observed value with its expected value.
   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS div semantics from 64-bit signed arithmetic, which avoids
   // the 32-bit overflow case.
   function automatic void refDiv(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
   endfunction

   // Issue one non-zero division right after a falling edge. While the divider
   // is busy, inject random start pulses and operands; they must be ignored.
   // The task returns on the falling edge where done is visible.
   task automatic runDiv(input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] expLo, expHi;
      int          busyCnt, doneAt;
      logic        zeroSeen;
      refDiv(av, bv, expLo, expHi);
      divIf.start = 1'b1;
      divIf.a     = av;
      divIf.b     = bv;
      busyCnt  = 0;
      doneAt   = 0;
      zeroSeen = 1'b0;
      for (int k = 1; k <= 40 && doneAt == 0; k++) begin
         @(negedge clk);
         if (k <= 33) begin
            divIf.start = 1'($urandom_range(0, 1));
            divIf.a     = $urandom;
            divIf.b     = $urandom;
         end else begin
            divIf.start = 1'b0;
         end
         if (divIf.busy) busyCnt++;
         if (divIf.div_zero) zeroSeen = 1'b1;
         if (divIf.done) doneAt = k;
      end
      divIf.start = 1'b0;
      checkEq($sformatf("latency %h/%h", av, bv), doneAt, 34);
      checkEq($sformatf("busyCycles %h/%h", av, bv), busyCnt, 33);
      checkEq($sformatf("lo %h/%h", av, bv), divIf.lo, expLo);
      checkEq($sformatf("hi %h/%h", av, bv), divIf.hi, expHi);
      checkEq($sformatf("noDivZero %h/%h", av, bv), zeroSeen, 0);
      lastHi = expHi;
      lastLo = expLo;
   endtask

   // Divide by zero: an immediate one-cycle done/div_zero, no busy, and hi/lo
   // are retained.
   task automatic runZero(input logic [31:0] av);
      divIf.start = 1'b1;
      divIf.a     = av;
      divIf.b     = 32'd0;
      @(negedge clk);
      divIf.start = 1'b0;
      checkEq("zeroDone", divIf.done, 1);
      checkEq("zeroFlag", divIf.div_zero, 1);
      checkEq("zeroBusy", divIf.busy, 0);
      checkEq("zeroHiKept", divIf.hi, lastHi);
      checkEq("zeroLoKept", divIf.lo, lastLo);
      @(negedge clk);
      checkEq("zeroDoneDrop", divIf.done, 0);
      checkEq("zeroFlagDrop", divIf.div_zero, 0);
   endtask

   // Main sequence.
   initial begin
      logic [31:0] av, bv;
      int          doneCnt;

      reset       = 1'b0;
      divIf.start = 1'b0;
      divIf.a     = 32'd0;
      divIf.b     = 32'd0;
      lastHi      = 32'd0;
      lastLo      = 32'd0;
      repeat (2) @(negedge clk);
      checkEq("rstHi", divIf.hi, 0);
      checkEq("rstLo", divIf.lo, 0);
      checkEq("rstBusy", divIf.busy, 0);
      checkEq("rstDone", divIf.done, 0);
      checkEq("rstDivZero", divIf.div_zero, 0);
      reset = 1'b1;
      @(negedge clk);

      // Basic cases; the next division starts in the cycle where done is high.
      runDiv(32'd7, 32'd2);
      checkEq("lo 7/2 const", divIf.lo, 32'h00000003);
      checkEq("hi 7/2 const", divIf.hi, 32'h00000001);
      runDiv(32'hFFFFFFF9, 32'd2);
      checkEq("lo -7/2 const", divIf.lo, 32'hFFFFFFFD);
      checkEq("hi -7/2 const", divIf.hi, 32'hFFFFFFFF);
      runDiv(32'd7, 32'hFFFFFFFE);
      checkEq("lo 7/-2 const", divIf.lo, 32'hFFFFFFFD);
      checkEq("hi 7/-2 const", divIf.hi, 32'h00000001);
      @(negedge clk);
      checkEq("donePulseOnce", divIf.done, 0);

      // Divide by zero after 7/2 keeps hi=1, lo=3.
      runDiv(32'd7, 32'd2);
      @(negedge clk);
      runZero(32'd5);
      checkEq("zeroKeepHi const", divIf.hi, 32'd1);
      checkEq("zeroKeepLo const", divIf.lo, 32'd3);

      // Overflow corner and magnitude extremes.
      runDiv(32'h80000000, 32'hFFFFFFFF);
      checkEq("lo ovf const", divIf.lo, 32'h80000000);
      checkEq("hi ovf const", divIf.hi, 32'h00000000);
      runDiv(32'd0, 32'd5);
      runDiv(32'h80000000, 32'd1);
      runDiv(32'd1, 32'h80000000);
      runDiv(32'h7FFFFFFF, 32'h80000000);
      runDiv(32'h80000000, 32'h80000000);
      runDiv(32'h80000001, 32'h7FFFFFFF);

      // Random operands with varied divisor magnitude and sign, random spacing.
      for (int i = 0; i < 24; i++) begin
         av = $urandom;
         bv = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) bv = ~bv + 32'd1;
         if ($urandom_range(0, 7) == 0) bv = 32'd0;
         if (bv == 32'd0) begin
            runZero(av);
         end else begin
            runDiv(av, bv);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset mid-division: a second start while busy, then reset at cycle 10.
      @(negedge clk);
      divIf.start = 1'b1;
      divIf.a     = 32'd100;
      divIf.b     = 32'd7;
      @(negedge clk);
      divIf.start = 1'b0;
      repeat (4) @(negedge clk);
      divIf.start = 1'b1;
      divIf.a     = 32'd999;
      divIf.b     = 32'd3;
      @(negedge clk);
      divIf.start = 1'b0;
      checkEq("busyBeforeReset", divIf.busy, 1);
      repeat (4) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkEq("midRstHi", divIf.hi, 0);
      checkEq("midRstLo", divIf.lo, 0);
      checkEq("midRstBusy", divIf.busy, 0);
      checkEq("midRstDone", divIf.done, 0);
      checkEq("midRstDivZero", divIf.div_zero, 0);
      @(negedge clk);
      reset  = 1'b1;
      lastHi = 32'd0;
      lastLo = 32'd0;
      doneCnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divIf.done) doneCnt++;
      end
      checkEq("noDoneAfterReset", doneCnt, 0);
      checkEq("idleAfterReset", divIf.busy, 0);
      runDiv(32'd100, 32'd7);
      checkEq("lo 100/7 const", divIf.lo, 32'd14);
      checkEq("hi 100/7 const", divIf.hi, 32'd2);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
